ysyx_23060187_isram: RTL

YSYX_23060187_ISRAM -- requirements
Module: ysyx_23060187_isram

---
 rtl/ysyx_23060187_isram.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ysyx_23060187_isram.sv
// Instruction SRAM with a fixed-latency fetch port and a preload write port.
// Optional macro YSYX_23060187_ISRAM_CHECK_EN turns misaligned/out-of-range fetches into nop + resp_err.
module ysyx_23060187_isram #(
    parameter int          DEPTH = 1024,
    parameter int          LAT   = 2,
    parameter logic [31:0] BASE  = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        resp_ready,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   addr;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] ld_idx;
    logic [31:0]   rd_word;

    // Byte address -> word index, modulo 2^32 then truncated to the array size.
    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return AW'(off >> 2);
    endfunction

`ifdef YSYX_23060187_ISRAM_CHECK_EN
    logic err_q;

    function automatic logic bad_addr(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
    endfunction

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign rd_idx = word_idx(addr);
    assign ld_idx = word_idx(ld_addr);

    // A preload landing on the word being read wins (write-first).
    assign rd_word = (ld_en && (ld_idx == rd_idx)) ? ld_data : mem[rd_idx];

    // Memory has no reset so preloaded contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr       <= BASE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_inst  <= 32'h0;
`ifdef YSYX_23060187_ISRAM_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr      <= req_addr;
                        cnt       <= 4'(LAT - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
`ifdef YSYX_23060187_ISRAM_CHECK_EN
                        if (bad_addr(addr)) begin
                            resp_inst <= 32'h00000013;
                            err_q     <= 1'b1;
                        end else begin
                            resp_inst <= rd_word;
                            err_q     <= 1'b0;
                        end
`else
                        resp_inst <= rd_word;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Returning to IDLE here means no request can be taken on the handshake edge.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
